result_drain_ctrl: RTL and testbench

Result drain controller for the TPU. It reads the deskewed partial-sum words that the systolic pipeline wrote into the result SRAM. It then streams them off-chip-side over a valid/ready interface. It owns the result SRAM address and read-select while busy, and sits beside the result SRAM as the reader counterpart of the result writer.

---
 rtl/tpu_pkg.sv | 21 ++
 rtl/result_out_fifo.sv | 63 ++++++
 rtl/result_drain_ctrl.sv | 149 ++++++++++++++
 tb/tb_result_drain_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tpu_pkg.sv
// Shared TPU definitions: default datapath widths and the result-drain FSM
// state encoding used by the drain controller and its output FIFO.
package tpu_pkg;

    localparam int ADDRESSSIZE_DEF     = 10;
    localparam int PARTIAL_SUM_BW_DEF  = 20;
    localparam int MATRIX_SIZE_DEF     = 8;
    localparam int WORDSIZE_RESULT_DEF = PARTIAL_SUM_BW_DEF * MATRIX_SIZE_DEF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } drain_state_e;

    // Width needed to hold an occupancy count of 0..depth.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/result_out_fifo.sv
// Small synchronous FIFO holding result words (plus a last-word tag) between
// the SRAM read port and the output stream; the head entry drives the stream.
module result_out_fifo
    import tpu_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = WORDSIZE_RESULT_DEF + 1,
    localparam int CNT_W = cnt_width(DEPTH),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic [CNT_W-1:0] o_count,
    output logic             o_valid
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    assign w_pop = i_pop & (r_count != '0);

    // NOTE: storage is reset on purpose so a mid-drain reset discards every
    // buffered word and the head (m_data) reads back as zero afterwards.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= next_ptr(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= next_ptr(r_rd_ptr);
            end
            case ({i_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_valid = (r_count != '0);

endmodule

// File: rtl/result_drain_ctrl.sv
// Result drain controller: reads num_words consecutive result-SRAM words from
// base_addr and streams them out over valid/ready, tagging the final word.
module result_drain_ctrl
    import tpu_pkg::*;
#(
    parameter int ADDRESSSIZE     = ADDRESSSIZE_DEF,
    parameter int PARTIAL_SUM_BW  = PARTIAL_SUM_BW_DEF,
    parameter int MATRIX_SIZE     = MATRIX_SIZE_DEF,
    parameter int WORDSIZE_Result = PARTIAL_SUM_BW * MATRIX_SIZE,
    parameter int BUF_DEPTH       = 2
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       start,
    input  logic [ADDRESSSIZE-1:0]     base_addr,
    input  logic [ADDRESSSIZE:0]       num_words,
    output logic                       busy,
    output logic                       done,
    output logic                       sram_rd_sel,
    output logic [ADDRESSSIZE-1:0]     sram_address,
    input  logic [WORDSIZE_Result-1:0] sram_data_in,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [WORDSIZE_Result-1:0] m_data,
    output logic                       m_last
);

    localparam int CNT_W = cnt_width(BUF_DEPTH);

    drain_state_e r_state;
    drain_state_e w_state_next;

    logic [ADDRESSSIZE-1:0] r_addr;
    logic [ADDRESSSIZE:0]   r_remaining;
    logic                   r_inflight;
    logic                   r_inflight_last;
    logic                   r_done;

    logic                   w_load;
    logic                   w_issue;
    logic                   w_final_issue;
    logic                   w_done_next;
    logic                   w_pop;
    logic                   w_fifo_valid;
    logic [CNT_W-1:0]       w_occ;
    logic [CNT_W:0]         w_level;
    logic [CNT_W:0]         w_limit;
    logic [WORDSIZE_Result:0] w_head;

    result_out_fifo #(
        .DEPTH (BUF_DEPTH),
        .WIDTH (WORDSIZE_Result + 1)
    ) u_out_fifo (
        .clk         (clk),
        .rstn        (rstn),
        .i_push      (r_inflight),
        .i_push_data ({r_inflight_last, sram_data_in}),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_count     (w_occ),
        .o_valid     (w_fifo_valid)
    );

    assign m_valid = w_fifo_valid;
    assign m_data  = w_head[WORDSIZE_Result-1:0];
    assign m_last  = w_fifo_valid & w_head[WORDSIZE_Result];
    assign w_pop   = w_fifo_valid & m_ready;

    // A read may issue when buffered + in-flight words, less this cycle's pop,
    // still leave a free slot for the data returning next cycle.
    assign w_level = (CNT_W+1)'(w_occ) + (CNT_W+1)'(r_inflight);
    assign w_limit = (CNT_W+1)'(BUF_DEPTH) + (CNT_W+1)'(w_pop);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        w_state_next  = r_state;
        w_load        = 1'b0;
        w_issue       = 1'b0;
        w_final_issue = 1'b0;
        w_done_next   = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    if (num_words != '0) begin
                        w_load       = 1'b1;
                        w_state_next = RUN;
                    end else begin
                        w_done_next = 1'b1;
                    end
                end
            end
            RUN: begin
                if (w_level < w_limit) begin
                    w_issue = 1'b1;
                    if (r_remaining == (ADDRESSSIZE+1)'(1)) begin
                        w_final_issue = 1'b1;
                        w_state_next  = FLUSH;
                    end
                end
            end
            FLUSH: begin
                // The tagged word leaving the head means nothing is left behind it.
                if (w_pop && m_last) begin
                    w_done_next  = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_addr          <= '0;
            r_remaining     <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_done          <= 1'b0;
        end else begin
            if (w_load) begin
                r_addr      <= base_addr;
                r_remaining <= num_words;
            end else if (w_issue) begin
                r_addr      <= r_addr + ADDRESSSIZE'(1);
                r_remaining <= r_remaining - (ADDRESSSIZE+1)'(1);
            end
            r_inflight      <= w_issue;
            r_inflight_last <= w_final_issue;
            r_done          <= w_done_next;
        end
    end

    assign busy         = (r_state != IDLE);
    assign done         = r_done;
    assign sram_rd_sel  = w_issue;
    assign sram_address = r_addr;

endmodule

// File: tb/tb_result_drain_ctrl.sv
// Self-checking bench for result_drain_ctrl: an SRAM model feeds the DUT and a
// queue-based reference of expected words checks the stream and its timing.
module tb_result_drain_ctrl;

    localparam int AW = 10;
    localparam int DW = 160;

    logic          clk;
    logic          rstn;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   num_words;
    logic          busy;
    logic          done;
    logic          sram_rd_sel;
    logic [AW-1:0] sram_address;
    logic [DW-1:0] sram_data_in;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          m_last;

    logic [DW-1:0] mem [1024];

    int n_checks = 0;
    int n_errors = 0;

    result_drain_ctrl dut (
        .clk          (clk),
        .rstn         (rstn),
        .start        (start),
        .base_addr    (base_addr),
        .num_words    (num_words),
        .busy         (busy),
        .done         (done),
        .sram_rd_sel  (sram_rd_sel),
        .sram_address (sram_address),
        .sram_data_in (sram_data_in),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .m_last       (m_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read SRAM: data for the address presented in a cycle is
    // available throughout the next cycle.
    always @(posedge clk) sram_data_in <= mem[sram_address];

    task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_busy"},  busy, 0);
        check({tag, "_done"},  done, 0);
        check({tag, "_rdsel"}, sram_rd_sel, 0);
        check({tag, "_addr"},  sram_address, 0);
        check({tag, "_valid"}, m_valid, 0);
        check({tag, "_data"},  m_data, 0);
        check({tag, "_last"},  m_last, 0);
    endtask

    // One drain transaction. rand_ready randomises m_ready per cycle,
    // extra_start re-pulses start while busy, abort_after>0 asserts reset
    // once that many words have been handshaken.
    task automatic run_drain(input logic [AW-1:0] base, input logic [AW:0] num,
                             input bit rand_ready, input bit extra_start,
                             input int abort_after);
        logic [DW-1:0] exp_q[$];
        bit            exp_last_q[$];
        logic [DW-1:0] held_data;
        logic [AW-1:0] exp_addr;
        bit            held_last;
        bit            stalled;
        bit            seen_done;
        bit            aborted;
        int            issued;
        int            hs;
        int            c;
        int            last_hs_c;
        int            budget;

        for (int i = 0; i < int'(num); i++) begin
            exp_addr = base + AW'(i);
            exp_q.push_back(mem[exp_addr]);
            exp_last_q.push_back(i == int'(num) - 1);
        end
        stalled   = 0;
        seen_done = 0;
        aborted   = 0;
        issued    = 0;
        hs        = 0;
        last_hs_c = -1;
        held_data = '0;
        held_last = 0;
        budget    = 20 * int'(num) + 20;

        @(posedge clk); #1;
        start     = 1'b1;
        base_addr = base;
        num_words = num;
        m_ready   = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        c     = 1;

        while (c < budget) begin
            @(negedge clk);
            if (c == 1 && num != 0) begin
                check("first_busy",  busy, 1);
                check("first_rdsel", sram_rd_sel, 1);
                check("first_addr",  sram_address, base);
            end
            if (num == 0) begin
                check("zero_busy",  busy, 0);
                check("zero_rdsel", sram_rd_sel, 0);
                check("zero_valid", m_valid, 0);
            end
            if (sram_rd_sel) begin
                exp_addr = base + AW'(issued);
                check("rd_addr", sram_address, exp_addr);
                issued++;
                check("rd_count", issued <= int'(num), 1);
            end
            if (stalled) begin
                check("stall_valid", m_valid, 1);
                check("stall_data",  m_data, held_data);
                check("stall_last",  m_last, held_last);
            end
            if (m_valid && m_ready) begin
                hs++;
                last_hs_c = c;
                if (exp_q.size() == 0) begin
                    check("extra_word", 1, 0);
                end else begin
                    check("word_data", m_data, exp_q.pop_front());
                    check("word_last", m_last, exp_last_q.pop_front());
                end
            end
            check("reads_ahead", (issued - hs) <= 2, 1);
            stalled   = m_valid && !m_ready;
            held_data = m_data;
            held_last = m_last;
            if (done) begin
                seen_done = 1;
                check("done_words", hs, int'(num));
                check("done_busy", busy, 0);
                if (num == 0)
                    check("done_zero_cycle", c, 1);
                else
                    check("done_cycle", c, last_hs_c + 1);
                if (!rand_ready && num != 0)
                    check("done_latency", c, 3 + int'(num));
                break;
            end
            if (abort_after > 0 && hs == abort_after) begin
                #2 rstn = 1'b0;
                #1 check_reset_values("abort");
                aborted = 1;
                break;
            end
            @(posedge clk); #1;
            c++;
            m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (extra_start && c == 2) begin
                start     = 1'b1;
                base_addr = base + AW'(100);
                num_words = 3;
            end else begin
                start = 1'b0;
            end
        end

        if (aborted) begin
            @(posedge clk); #1;
            check("abort_hold_valid", m_valid, 0);
            check("abort_hold_busy",  busy, 0);
            @(negedge clk);
            rstn = 1'b1;
        end else begin
            if (!seen_done) check("done_timeout", 0, 1);
            start = 1'b0;
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                check("no_extra_done", done, 0);
                check("idle_busy",     busy, 0);
                check("idle_valid",    m_valid, 0);
            end
        end
    endtask

    initial begin
        logic [19:0] lane;
        logic [AW-1:0] rb;
        logic [AW:0]   rn;

        rstn      = 1'b0;
        start     = 1'b0;
        base_addr = '0;
        num_words = '0;
        m_ready   = 1'b0;
        for (int i = 0; i < 1024; i++) begin
            mem[i] = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        end
        for (int i = 0; i < 4; i++) begin
            lane   = 20'hA0 + 20'(i);
            mem[i] = {8{lane}};
        end

        #12;
        check_reset_values("reset");
        @(negedge clk);
        rstn = 1'b1;

        run_drain(10'd0,    11'd4, 0, 0, 0);
        run_drain(10'd5,    11'd0, 0, 0, 0);
        run_drain(10'd1022, 11'd4, 0, 0, 0);
        run_drain(10'd37,   11'd6, 1, 0, 0);
        run_drain(10'd200,  11'd5, 0, 1, 0);
        run_drain(10'd250,  11'd6, 1, 1, 0);
        run_drain(10'd300,  11'd8, 0, 0, 2);
        run_drain(10'd512,  11'd8, 1, 0, 0);
        run_drain(10'd700,  11'd8, 0, 0, 0);

        for (int t = 0; t < 12; t++) begin
            rb = AW'($urandom_range(0, 1023));
            rn = (AW+1)'($urandom_range(0, 14));
            run_drain(rb, rn, 1'($urandom_range(0, 1)), 0, 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
